// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key schedule controller: FSM states,
// round-constant values and the GF(2^8) doubling used to advance rcon.
package aes_pkg;

  localparam int NUM_ROUNDS_DEF = 10;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    GAP,
    DONE,
    ERR
  } ks_state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/key_store.sv
// Round-key register file: one synchronous write port, one combinational read
// port; entries beyond DEPTH read as zero.
module key_store #(
  parameter int DEPTH = 11,
  parameter int AW    = 4,
  parameter int DW    = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem[gi] <= '0;
      end else if (we && (waddr == AW'(gi))) begin
        mem[gi] <= wdata;
      end
    end
  end

  // Decoded read keeps out-of-range indices at zero without indexing past DEPTH.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == AW'(i)) begin
        rdata = mem[i];
      end
    end
  end

endmodule

// File: rtl/key_sched_ctrl.sv
// AES-128 key-expansion sequencer: drives an external round-function datapath
// one round at a time and collects its results into the round-key store.
module key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int TIMEOUT    = 64,
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic         keys_valid_o,
  input  logic [3:0]   rk_idx_i,
  output logic [127:0] rk_o,
  output logic         dp_en_o,
  output logic [31:0]  dp_word_o,
  output logic [7:0]   dp_rcon_o,
  output logic [127:0] dp_key_prev_o,
  input  logic         dp_ready_i,
  input  logic [127:0] dp_key_i
);

  localparam int IDXW = 4;
  localparam int WDW  = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0]  WD_LAST    = WDW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0] LAST_ROUND = IDXW'(NUM_ROUNDS);

  ks_state_t       state_reg, state_next;
  logic [IDXW-1:0] round_reg, round_next;
  logic [7:0]      rcon_reg, rcon_next;
  logic [WDW-1:0]  wdog_reg, wdog_next;
  logic            keys_valid_reg, keys_valid_next;
  logic [127:0]    prev_key_reg, prev_key_next;

  logic            st_we;
  logic [IDXW-1:0] st_waddr;
  logic [127:0]    st_wdata;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      round_reg      <= '0;
      rcon_reg       <= RCON_INIT;
      wdog_reg       <= '0;
      keys_valid_reg <= 1'b0;
      prev_key_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      round_reg      <= round_next;
      rcon_reg       <= rcon_next;
      wdog_reg       <= wdog_next;
      keys_valid_reg <= keys_valid_next;
      prev_key_reg   <= prev_key_next;
    end
  end

  // prev_key_reg mirrors rk[round-1] so the store needs only one read port.
  always_comb begin
    state_next      = state_reg;
    round_next      = round_reg;
    rcon_next       = rcon_reg;
    wdog_next       = wdog_reg;
    keys_valid_next = keys_valid_reg;
    prev_key_next   = prev_key_reg;
    st_we           = 1'b0;
    st_waddr        = '0;
    st_wdata        = '0;

    unique case (state_reg)
      IDLE: begin
        if (start_i) begin
          st_we           = 1'b1;
          st_waddr        = '0;
          st_wdata        = key_i;
          prev_key_next   = key_i;
          round_next      = IDXW'(1);
          rcon_next       = RCON_INIT;
          wdog_next       = '0;
          keys_valid_next = 1'b0;
          state_next      = RUN;
        end
      end

      RUN: begin
        // A ready on the final watchdog cycle still counts as success.
        if (dp_ready_i) begin
          st_we         = 1'b1;
          st_waddr      = round_reg;
          st_wdata      = dp_key_i;
          prev_key_next = dp_key_i;
          if (round_reg == LAST_ROUND) begin
            state_next = DONE;
          end else begin
            round_next = round_reg + IDXW'(1);
            rcon_next  = xtime(rcon_reg);
            state_next = GAP;
          end
        end else begin
          wdog_next = wdog_reg + WDW'(1);
          if (wdog_reg == WD_LAST) begin
            state_next = ERR;
          end
        end
      end

      GAP: begin
        wdog_next  = '0;
        state_next = RUN;
      end

      DONE: begin
        keys_valid_next = 1'b1;
        state_next      = IDLE;
      end

      ERR: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy_o        = (state_reg != IDLE);
  assign done_o        = (state_reg == DONE);
  assign err_o         = (state_reg == ERR);
  assign dp_en_o       = (state_reg == RUN);
  assign keys_valid_o  = keys_valid_reg;
  assign dp_key_prev_o = dp_en_o ? prev_key_reg : '0;
  assign dp_word_o     = dp_en_o ? prev_key_reg[31:0] : '0;
  assign dp_rcon_o     = dp_en_o ? rcon_reg : '0;

  key_store #(
    .DEPTH (NUM_ROUNDS + 1),
    .AW    (IDXW),
    .DW    (128)
  ) u_store (
    .clk   (clk_i),
    .rst_n (rst_n),
    .we    (st_we),
    .waddr (st_waddr),
    .wdata (st_wdata),
    .raddr (rk_idx_i),
    .rdata (rk_o)
  );

endmodule

// File: doc/key_sched_ctrl.md
KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, max cycles to wait for datapath ready per round.
REQ-002 SHALL have parameter NUM_ROUNDS, default 10, number of expanded round keys (AES-128).
REQ-003 clk_i  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  begin expansion of key_i; sampled only in IDLE.
REQ-006 key_i  input  128  cipher key, captured on accepted start_i.
REQ-007 busy_o  output  1  high from accepted start until return to IDLE.
REQ-008 done_o  output  1  one-cycle pulse when all round keys are stored.
REQ-009 err_o  output  1  one-cycle pulse on datapath timeout.
REQ-010 keys_valid_o  output  1  level; round-key store complete and coherent.
REQ-011 rk_idx_i  input  4  round-key read index 0..10.
REQ-012 rk_o  output  128  combinational read of stored key rk_idx_i; 0 if index > NUM_ROUNDS.
REQ-013 dp_en_o  output  1  enable to the key-round datapath (F function block).
REQ-014 dp_word_o  output  32  last word (bits 31:0) of previous round key.
REQ-015 dp_rcon_o  output  8  round constant for the current round.
REQ-016 dp_key_prev_o  output  128  previous round key.
REQ-017 dp_ready_i  input  1  datapath result valid this cycle.
REQ-018 dp_key_i  input  128  datapath result (next round key).

Function
REQ-019 FSM states SHALL be IDLE, RUN, GAP, DONE, ERR.
REQ-020 IDLE: on start_i=1, store key_i as rk[0], round<=1, rcon<=8'h01, keys_valid_o<=0, go to RUN; else stay.
REQ-021 RUN: dp_en_o=1, dp_word_o/dp_key_prev_o driven from rk[round-1], dp_rcon_o=rcon; inputs stable for whole state.
REQ-022 RUN with dp_ready_i=1: store dp_key_i into rk[round]; if round==NUM_ROUNDS go to DONE, else round+1, rcon<=xtime(rcon), go to GAP.
REQ-023 GAP: dp_en_o=0 for exactly one cycle (datapath restart), then RUN.
REQ-024 xtime SHALL be {rcon[6:0],1'b0} XOR (rcon[7] ? 8'h1B : 8'h00); sequence 01,02,04,08,10,20,40,80,1B,36.
REQ-025 Watchdog counter SHALL clear on entry to RUN, increment each RUN cycle without dp_ready_i; reaching TIMEOUT goes to ERR.
REQ-026 DONE: done_o=1, keys_valid_o<=1, next IDLE (one cycle).
REQ-027 ERR: err_o=1, keys_valid_o stays 0, dp_en_o=0, next IDLE (one cycle).
REQ-028 busy_o=1 in RUN, GAP, DONE, ERR; 0 in IDLE.
REQ-029 start_i outside IDLE SHALL be ignored, no queuing.
REQ-030 dp_ready_i outside RUN SHALL be ignored, store unchanged.
REQ-031 dp_ready_i on the same cycle the watchdog hits TIMEOUT: the ready wins (key stored, no error).
REQ-032 Latency start->done_o = 1 + sum(per-round RUN cycles) + (NUM_ROUNDS-1) GAP cycles.
REQ-033 rk_o reads stored contents at all times; a read during an expansion returns partially updated data (keys_valid_o=0).

Reset
REQ-034 rst_n low SHALL force IDLE, round=0, rcon=8'h01, watchdog=0, and all outputs 0, including mid-expansion.
REQ-035 Round-key storage SHALL clear to 0 on reset.

Structure
REQ-036 Shared package aes_pkg SHALL hold the state enum, NUM_ROUNDS default, RCON_INIT=8'h01, RCON_POLY=8'h1B and the xtime function.
REQ-037 Storage SHALL be a sub-module key_store (11x128 registers, one write port, one combinational read port); the FSM, counters and rcon stay in key_sched_ctrl.

Verification
REQ-038 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, bench F model with ready after 3 cycles -> done_o once; rk[1]=a0fafe1788542cb123a339392a6c7605, rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6; keys_valid_o=1.
REQ-039 Monitor dp_rcon_o across a full run -> exactly 01,02,04,08,10,20,40,80,1B,36 in order, dp_en_o low for one cycle between rounds.
REQ-040 Datapath never asserts ready at round 4, TIMEOUT=64 -> err_o pulse on 64th RUN cycle, keys_valid_o=0, busy_o low next cycle.
REQ-041 rst_n pulsed low during round 6 -> immediately IDLE, busy_o=0, rk_o=0 for every index; new start completes normally.
REQ-042 start_i held high throughout a run, with dp_ready_i pulsed in GAP -> single expansion, store unaffected by GAP ready, restart only after IDLE.
REQ-043 rk_idx_i=11..15 -> rk_o=0; ready arriving on the same cycle as timeout -> key stored, no err_o.
